// File: rtl/dram_cmd_pkg.sv
// dram_cmd_pkg: DRAM command opcodes and refresh sequencer state encoding
package dram_cmd_pkg;
    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_ACT   = 3'd1,
        CMD_READ  = 3'd2,
        CMD_WRITE = 3'd3,
        CMD_PREA  = 3'd4,
        CMD_REF   = 3'd5
    } cmd_op_e;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRAIN     = 3'd1,
        PREA      = 3'd2,
        WAIT_RP   = 3'd3,
        REF       = 3'd4,
        WAIT_DONE = 3'd5
    } state_e;
endpackage

// File: rtl/refresh_cmd_sequencer.sv
// refresh_cmd_sequencer: blocks host commands, issues PREA then REF, reopens host path
module refresh_cmd_sequencer
    import dram_cmd_pkg::*;
#(
    parameter int ADDR_W   = 27,
    parameter int T_RP     = 4,
    parameter int WATCHDOG = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              refresh_needed,
    output logic              refresh,
    input  logic              banks_idle,
    input  logic              host_cmd_valid,
    output logic              host_cmd_ready,
    input  logic [2:0]        host_cmd_op,
    input  logic [ADDR_W-1:0] host_cmd_addr,
    output logic              dram_cmd_valid,
    input  logic              dram_cmd_ready,
    output logic [2:0]        dram_cmd_op,
    output logic [ADDR_W-1:0] dram_cmd_addr,
    output logic              refresh_active,
    output logic              refresh_timeout,
    output logic [15:0]       refresh_count
);
    state_e      state;
    logic [7:0]  rp_cnt;
    logic [15:0] wd_cnt;
    logic        idle;
    always_comb begin
        idle           = state == IDLE;
        refresh_active = !idle;
        dram_cmd_valid = idle ? host_cmd_valid : (state == PREA || state == REF);
        dram_cmd_op    = idle ? host_cmd_op : (state == REF ? CMD_REF : CMD_PREA);
        dram_cmd_addr  = idle ? host_cmd_addr : '0;
        host_cmd_ready = idle && dram_cmd_ready;
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state           <= IDLE;
            refresh         <= 1'b0;
            refresh_timeout <= 1'b0;
            refresh_count   <= '0;
            rp_cnt          <= '0;
            wd_cnt          <= '0;
        end else begin
            refresh <= 1'b0;
            case (state)
                IDLE:    if (refresh_needed && !(host_cmd_valid && !dram_cmd_ready)) state <= DRAIN;
                DRAIN:   if (banks_idle) state <= PREA;
                PREA:    if (dram_cmd_ready) begin
                    rp_cnt <= 8'(T_RP);
                    state  <= WAIT_RP;
                end
                WAIT_RP: begin
                    rp_cnt <= rp_cnt - 8'd1;
                    if (rp_cnt == 8'd1) state <= REF;
                end
                REF:     if (dram_cmd_ready) begin
                    refresh       <= 1'b1;
                    refresh_count <= refresh_count + 16'd1;
                    wd_cnt        <= '0;
                    state         <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    wd_cnt <= wd_cnt + 16'd1;
                    if (!refresh_needed) state <= IDLE;
                    else if (wd_cnt == 16'(WATCHDOG - 1)) begin
                        refresh_timeout <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
